multiboot_request: RTL
======================

# multiboot_request

Register-mapped front end that stages a target SPI flash bitstream address and issues a clean reboot request to the downstream ICAP multiboot sequencer. CPU writes the 24-bit address one byte at a time through the core's internal register port, then triggers a reboot. The block commits the address and drives a pulse on `REBOOT` shaped for the sequencer's falling-edge detector. An optional hold-to-recover hotkey forces a reboot to the default slot.

## Interface
Parameters:
- `DEFAULT_ADDR`, 24'h0B0000: committed and staged address after reset; hotkey target.
- `REG_SPIADDR`, 8'hFB: register number of the staged-address byte port.
- `REG_BOOTCTL`, 8'hFC: register number of the control register.
- `PULSE_CYCLES`, 16: `REBOOT` high time, in cycles. Minimum 1.
- `TAIL_CYCLES`, 8: `REBOOT` low guard time after the pulse. Minimum 4.
- `HOTKEY_CYCLES`, 24'd5_000_000: hotkey hold time, in cycles.

Ports:
- `clk_icap` in 1: single clock; same clock as the sequencer.
- `rst_n` in 1: asynchronous, active-low reset.
- `reg_addr` in 8: register number.
- `reg_wr` in 1: write strobe, one cycle.
- `reg_din` in 8: write data.
- `reg_dout` out 8: read data, combinational from `reg_addr`.
- `reg_oe` out 1: high when `reg_addr` matches either register.
- `hotkey` in 1: level, already synchronised. Only used with the macro.
- `spi_addr` out 24: committed address to the sequencer.
- `REBOOT` out 1: reboot request to the sequencer.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Staging register `stage[23:0]` plus a 2-bit byte pointer `ptr`.
- Write to `REG_SPIADDR`:
  - stores `reg_din` into byte `ptr` (0 = [7:0], 1 = [15:8], 2 = [23:16]);
  - `ptr` then advances 0→1→2→0 (wraps after 2).
- Write to `REG_BOOTCTL`:
  - bit1 = 1 clears `ptr` to 0;
  - bit0 = 1 triggers a reboot;
  - both bits set: clear `ptr` and trigger in the same cycle.
- Reads:
  - `REG_SPIADDR` returns `stage` byte `ptr`; reads do not advance `ptr`.
  - `REG_BOOTCTL` returns {5'b0, hotkey_active, ptr==0, busy}.
  - Any other `reg_addr`: `reg_dout` = 8'hFF and `reg_oe` = 0.
- State machine: IDLE, PULSE, TAIL.
  - IDLE → PULSE on trigger. At that edge: `spi_addr` ← `stage`, and the pulse counter loads `PULSE_CYCLES-1`.
  - PULSE: `REBOOT` = 1. Counter decrements each cycle; at 0, go to TAIL and load `TAIL_CYCLES-1`.
  - TAIL: `REBOOT` = 0. At counter 0, go to IDLE.
- Register writes while `busy`:
  - ignored entirely, including `stage`, `ptr` and the trigger;
  - `spi_addr` stays stable for the whole sequence.
- `REBOOT` is a registered output; it is never high outside PULSE.
- Counter width is `$clog2` of the larger of `PULSE_CYCLES` and `TAIL_CYCLES`, plus 1.

## Timing
- Reset values:
  - `spi_addr` = `DEFAULT_ADDR`, `stage` = `DEFAULT_ADDR`, `ptr` = 0;
  - `REBOOT` = 0, `busy` = 0, state = IDLE, all counters 0.
- Trigger write sampled at edge N:
  - `spi_addr` is valid from N;
  - `REBOOT` is high for edges N..N+PULSE_CYCLES-1 (exactly `PULSE_CYCLES` cycles);
  - `REBOOT` is low from N+PULSE_CYCLES;
  - `busy` drops after N+PULSE_CYCLES+TAIL_CYCLES.
- Earliest re-trigger is the cycle `busy` reads 0.
- Reset asserted mid-sequence: `REBOOT` drops immediately (asynchronous) and all state returns to reset values. A partial pulse is acceptable; the sequencer triggers on the falling edge.
- Register-port latency: write effects are visible on the next cycle's read.

## Configuration
- `MULTIBOOT_HOTKEY_EN` defined:
  - a 24-bit saturating counter increments while `hotkey` = 1 and clears when `hotkey` = 0;
  - reaching `HOTKEY_CYCLES` in IDLE triggers a reboot with `spi_addr` ← `DEFAULT_ADDR`, and `stage` is left untouched;
  - the counter then holds at saturation and cannot re-arm until `hotkey` has been low for at least one cycle;
  - if the hotkey threshold and a software trigger occur in the same cycle, the hotkey wins and the target is `DEFAULT_ADDR`;
  - `hotkey_active` = (counter ≠ 0).
- Macro undefined: the `hotkey` input is unused, the counter logic is absent, and `hotkey_active` reads 0.

## Structure
- Shared package `multiboot_pkg`:
  - state enum (IDLE, PULSE, TAIL);
  - register-number constants;
  - `BOOTCTL` bit positions;
  - default lx16/lx25 slot addresses (24'h098000, 24'h0B0000).
- One natural sub-module, `multiboot_hotkey`: hold counter with saturation and re-arm logic, compiled only under the macro.

## Test plan
- Reset, then write FB ← 00, 00, 0A, then FC ← 01 → `spi_addr` = 24'h0A0000; `REBOOT` high exactly 16 cycles, then low; `busy` high for 24 cycles.
- Write FB ← 11, 22 (ptr = 2), then FC ← 02, then FB ← 33 → `stage` byte 0 = 33h; read FB returns 22h after pointer advance to 1; ptr wrap 2→0 checked.
- During PULSE, write FB ← 55 and FC ← 01 → `stage` and `spi_addr` unchanged, no second pulse, `busy` timing unchanged.
- Assert `rst_n` low at pulse cycle 5 → `REBOOT` = 0 immediately; `spi_addr` = 24'h0B0000 after release.
- With `MULTIBOOT_HOTKEY_EN` and `HOTKEY_CYCLES` = 100, `stage` = 24'h0A0000: hold `hotkey` 99 cycles then release → no pulse; hold 100 cycles → pulse with `spi_addr` = 24'h0B0000; keep holding → no re-trigger.
- Without the macro, hold `hotkey` for 1000 cycles → `REBOOT` stays 0 and FC read bit2 = 0.

Source files
------------

// File: rtl/multiboot_pkg.sv
// Shared types and constants for the multiboot reboot-request front end.
package multiboot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    TAIL  = 2'd2
  } state_t;

  localparam logic [7:0] MB_REG_SPIADDR = 8'hFB;
  localparam logic [7:0] MB_REG_BOOTCTL = 8'hFC;

  // BOOTCTL write bits
  localparam int unsigned BOOTCTL_TRIG = 0;
  localparam int unsigned BOOTCTL_CLR  = 1;

  localparam logic [23:0] SLOT_LX16 = 24'h098000;
  localparam logic [23:0] SLOT_LX25 = 24'h0B0000;

endpackage

// File: rtl/multiboot_hotkey.sv
// Hold-to-recover hotkey: saturating hold counter that fires once per press.
// Only compiled when MULTIBOOT_HOTKEY_EN is defined.
`ifdef MULTIBOOT_HOTKEY_EN
module multiboot_hotkey #(
  parameter logic [23:0] HOTKEY_CYCLES = 24'd5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hotkey,
  input  logic idle,
  output logic fire_c,
  output logic active_c
);

  logic [23:0] cnt;
  logic        done;

  // Counter clears on release; a press fires at most once, and only from idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 24'd0;
      done <= 1'b0;
    end else if (!hotkey) begin
      cnt  <= 24'd0;
      done <= 1'b0;
    end else begin
      if (cnt != HOTKEY_CYCLES) cnt <= cnt + 24'd1;
      if (fire_c) done <= 1'b1;
    end
  end

  assign fire_c   = idle && !done && (cnt == HOTKEY_CYCLES);
  assign active_c = (cnt != 24'd0);

endmodule
`endif

// File: rtl/multiboot_request.sv
// Stages a 24-bit SPI flash address via a byte register port and issues a shaped
// REBOOT pulse to the ICAP sequencer. Optional hotkey recovery: MULTIBOOT_HOTKEY_EN.
module multiboot_request
  import multiboot_pkg::*;
#(
  parameter logic [23:0] DEFAULT_ADDR  = SLOT_LX25,
  parameter logic [7:0]  REG_SPIADDR   = MB_REG_SPIADDR,
  parameter logic [7:0]  REG_BOOTCTL   = MB_REG_BOOTCTL,
  parameter int unsigned PULSE_CYCLES  = 16,
  parameter int unsigned TAIL_CYCLES   = 8,
  parameter logic [23:0] HOTKEY_CYCLES = 24'd5_000_000
) (
  input  logic        clk_icap,
  input  logic        rst_n,
  input  logic [7:0]  reg_addr,
  input  logic        reg_wr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic        reg_oe,
  input  logic        hotkey,
  output logic [23:0] spi_addr,
  output logic        REBOOT,
  output logic        busy
);

  localparam int unsigned MAX_CYCLES = (PULSE_CYCLES > TAIL_CYCLES) ? PULSE_CYCLES : TAIL_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES) + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [23:0]   stage, stage_nxt;
  logic [23:0]   spi_addr_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic          reboot_nxt, busy_nxt;
  logic          wr_spi_c, wr_ctl_c, sw_trig_c;
  logic          hotkey_fire_c, hotkey_active_c;

`ifdef MULTIBOOT_HOTKEY_EN
  multiboot_hotkey #(
    .HOTKEY_CYCLES(HOTKEY_CYCLES)
  ) u_hotkey (
    .clk      (clk_icap),
    .rst_n    (rst_n),
    .hotkey   (hotkey),
    .idle     (state == IDLE),
    .fire_c   (hotkey_fire_c),
    .active_c (hotkey_active_c)
  );
`else
  logic hotkey_unused;
  assign hotkey_unused   = hotkey ^ (^HOTKEY_CYCLES);
  assign hotkey_fire_c   = 1'b0;
  assign hotkey_active_c = 1'b0;
`endif

  // Register writes are accepted only while idle
  assign wr_spi_c  = reg_wr && (reg_addr == REG_SPIADDR) && (state == IDLE);
  assign wr_ctl_c  = reg_wr && (reg_addr == REG_BOOTCTL) && (state == IDLE);
  assign sw_trig_c = wr_ctl_c && reg_din[BOOTCTL_TRIG];

  always_ff @(posedge clk_icap or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      stage    <= DEFAULT_ADDR;
      ptr      <= 2'd0;
      spi_addr <= DEFAULT_ADDR;
      REBOOT   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      stage    <= stage_nxt;
      ptr      <= ptr_nxt;
      spi_addr <= spi_addr_nxt;
      REBOOT   <= reboot_nxt;
      busy     <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stage_nxt    = stage;
    ptr_nxt      = ptr;
    spi_addr_nxt = spi_addr;

    if (wr_spi_c) begin
      case (ptr)
        2'd0:    stage_nxt[7:0]   = reg_din;
        2'd1:    stage_nxt[15:8]  = reg_din;
        2'd2:    stage_nxt[23:16] = reg_din;
        default: stage_nxt        = stage;
      endcase
      ptr_nxt = (ptr >= 2'd2) ? 2'd0 : ptr + 2'd1;
    end
    if (wr_ctl_c && reg_din[BOOTCTL_CLR]) ptr_nxt = 2'd0;

    case (state)
      IDLE: begin
        // Hotkey takes priority over a simultaneous software trigger
        if (hotkey_fire_c) begin
          state_nxt    = PULSE;
          cnt_nxt      = CW'(PULSE_CYCLES - 1);
          spi_addr_nxt = DEFAULT_ADDR;
        end else if (sw_trig_c) begin
          state_nxt    = PULSE;
          cnt_nxt      = CW'(PULSE_CYCLES - 1);
          spi_addr_nxt = stage;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_nxt = TAIL;
          cnt_nxt   = CW'(TAIL_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      TAIL: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    reboot_nxt = (state_nxt == PULSE);
    busy_nxt   = (state_nxt != IDLE);
  end

  // Combinational read port
  always_comb begin
    reg_dout = 8'hFF;
    reg_oe   = 1'b0;
    if (reg_addr == REG_SPIADDR) begin
      reg_oe = 1'b1;
      case (ptr)
        2'd0:    reg_dout = stage[7:0];
        2'd1:    reg_dout = stage[15:8];
        2'd2:    reg_dout = stage[23:16];
        default: reg_dout = 8'h00;
      endcase
    end else if (reg_addr == REG_BOOTCTL) begin
      reg_oe   = 1'b1;
      reg_dout = {5'b0, hotkey_active_c, (ptr == 2'd0), busy};
    end
  end

endmodule
